// File: rtl/if_fetch_stage.sv
// -----------------------------------------------------------------------------
// if_fetch_stage
//
// Instruction-fetch stage of a 5-stage RV32I pipeline. Owns the PC, issues one
// outstanding request at a time to instruction memory, and fills the IF/ID
// pipeline register consumed by decode. Downstream redirects (jal, branch,
// jalr) replace the PC and squash any wrong-path fetch. A one-entry skid buffer
// holds a response that returns while decode is stalled.
//
// Ports:
//   clk, rst           clock (rising edge), synchronous active-high reset
//   imem_req/addr      fetch request and word-aligned address
//   imem_gnt           request accepted this cycle
//   imem_rvalid/rdata  response valid and fetched instruction
//   id_stall           decode cannot accept a new instruction this cycle
//   redirect_valid/pc  control-flow redirect and its target
//   if_id_valid/pc/pc4/inst  IF/ID pipeline register contents
// -----------------------------------------------------------------------------
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        id_stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_id_valid,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc4,
    output logic [31:0] if_id_inst
);

    // REQ : request on the bus, waiting for a grant
    // WAIT: granted, waiting for the response of a correct-path fetch
    // HOLD: response parked in the skid buffer until IF/ID frees up
    // DROP: granted fetch became wrong-path; swallow its response
    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2,
        ST_DROP = 2'd3
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] skid_pc_reg, skid_pc_next;
    logic [31:0] skid_inst_reg, skid_inst_next;

    logic        if_id_valid_reg, if_id_valid_next;
    logic [31:0] if_id_pc_reg, if_id_pc_next;
    logic [31:0] if_id_pc4_reg, if_id_pc4_next;
    logic [31:0] if_id_inst_reg, if_id_inst_next;

    logic        can_load;
    logic        load_en;
    logic [31:0] load_pc;
    logic [31:0] load_inst;
    logic [31:0] pc_plus4;
    logic [31:0] redirect_aligned;

    // Redirect targets are forced to word alignment; the low bits carry no
    // meaning here (misalignment is trapped elsewhere).
    logic unused_redirect_bits;
    assign unused_redirect_bits = ^redirect_pc[1:0];
    assign redirect_aligned     = {redirect_pc[31:2], 2'b00};

    assign pc_plus4  = pc_reg + 32'd4;
    assign can_load  = !if_id_valid_reg || !id_stall;

    // Request is a pure function of state, masked while reset is asserted.
    assign imem_req  = (state_reg == ST_REQ) && !rst;
    assign imem_addr = {pc_reg[31:2], 2'b00};

    // ------------------------------------------------------------------
    // Fetch FSM: next state, PC, skid buffer and IF/ID load source
    // ------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        pc_next        = pc_reg;
        skid_pc_next   = skid_pc_reg;
        skid_inst_next = skid_inst_reg;
        load_en        = 1'b0;
        load_pc        = pc_reg;
        load_inst      = imem_rdata;

        unique case (state_reg)
            ST_REQ: begin
                if (redirect_valid) begin
                    pc_next = redirect_aligned;
                end
                if (imem_gnt) begin
                    // A fetch granted in the redirect cycle is already stale.
                    state_next = redirect_valid ? ST_DROP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (redirect_valid) begin
                    pc_next    = redirect_aligned;
                    state_next = imem_rvalid ? ST_REQ : ST_DROP;
                end else if (imem_rvalid) begin
                    pc_next = pc_plus4;
                    if (can_load) begin
                        load_en    = 1'b1;
                        load_pc    = pc_reg;
                        load_inst  = imem_rdata;
                        state_next = ST_REQ;
                    end else begin
                        skid_pc_next   = pc_reg;
                        skid_inst_next = imem_rdata;
                        state_next     = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                // pc already points past the parked instruction.
                if (redirect_valid) begin
                    pc_next    = redirect_aligned;
                    state_next = ST_REQ;
                end else if (can_load) begin
                    load_en    = 1'b1;
                    load_pc    = skid_pc_reg;
                    load_inst  = skid_inst_reg;
                    state_next = ST_REQ;
                end
            end
            ST_DROP: begin
                // Latest redirect wins while the stale response is pending.
                if (redirect_valid) begin
                    pc_next = redirect_aligned;
                end
                if (imem_rvalid) begin
                    state_next = ST_REQ;
                end
            end
            default: begin
                state_next = ST_REQ;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // IF/ID register: flush beats stall, stall beats load
    // ------------------------------------------------------------------
    always_comb begin
        if_id_valid_next = if_id_valid_reg;
        if_id_pc_next    = if_id_pc_reg;
        if_id_pc4_next   = if_id_pc4_reg;
        if_id_inst_next  = if_id_inst_reg;

        if (redirect_valid) begin
            if_id_valid_next = 1'b0;
            if_id_inst_next  = NOP_INST;
        end else if (if_id_valid_reg && id_stall) begin
            if_id_valid_next = 1'b1;
        end else if (load_en) begin
            if_id_valid_next = 1'b1;
            if_id_pc_next    = load_pc;
            if_id_pc4_next   = load_pc + 32'd4;
            if_id_inst_next  = load_inst;
        end else begin
            if_id_valid_next = 1'b0;
            if_id_inst_next  = NOP_INST;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_REQ;
            pc_reg          <= RESET_PC;
            skid_pc_reg     <= 32'h0;
            skid_inst_reg   <= NOP_INST;
            if_id_valid_reg <= 1'b0;
            if_id_pc_reg    <= 32'h0;
            if_id_pc4_reg   <= 32'h4;
            if_id_inst_reg  <= NOP_INST;
        end else begin
            state_reg       <= state_next;
            pc_reg          <= pc_next;
            skid_pc_reg     <= skid_pc_next;
            skid_inst_reg   <= skid_inst_next;
            if_id_valid_reg <= if_id_valid_next;
            if_id_pc_reg    <= if_id_pc_next;
            if_id_pc4_reg   <= if_id_pc4_next;
            if_id_inst_reg  <= if_id_inst_next;
        end
    end

    assign if_id_valid = if_id_valid_reg;
    assign if_id_pc    = if_id_pc_reg;
    assign if_id_pc4   = if_id_pc4_reg;
    assign if_id_inst  = if_id_inst_reg;

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage RV32I pipeline.
- Owns the PC register and issues single-outstanding requests to instruction memory.
- Feeds the IF/ID pipeline register consumed by decode, including the jal target adder in ID.
- Accepts redirect targets (jal, branch, jalr) from downstream and flushes wrong-path fetches; a 1-entry skid buffer absorbs a response that arrives while ID is stalled.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset
- NOP_INST, 32'h0000_0013, IF/ID instruction value when invalid (addi x0,x0,0)

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, synchronous, active-high
- imem_req  output  1  fetch request
- imem_addr  output  32  fetch address (word aligned)
- imem_gnt  input  1  request accepted this cycle
- imem_rvalid  input  1  response data valid
- imem_rdata  input  32  fetched instruction
- id_stall  input  1  ID cannot accept a new instruction this cycle
- redirect_valid  input  1  control-flow redirect this cycle
- redirect_pc  input  32  redirect target
- if_id_valid  output  1  IF/ID holds a valid instruction
- if_id_pc  output  32  PC of the IF/ID instruction
- if_id_pc4  output  32  if_id_pc + 4, mod 2^32
- if_id_inst  output  32  IF/ID instruction

Behaviour:
- **Clock and reset:** one clock, clk. Reset rst is synchronous and active-high.
- **Reset values:** pc=RESET_PC, state=REQ, skid empty, if_id_valid=0, if_id_pc=0, if_id_pc4=4, if_id_inst=NOP_INST. imem_req=0 in any cycle with rst=1. Reset mid-fetch discards all state; a stale imem_rvalid after reset is ignored only if it arrives in DROP (imem guarantees no response after rst).
- **Memory contract:**
  - Max one outstanding request.
  - Exactly one response per grant, at least 1 cycle after the grant.
  - The gnt cycle never carries rvalid for the same request.
- **pc:** internal register; imem_addr = {pc[31:2],2'b00}. redirect_pc[1:0] ignored (cleared); no misalignment trap here.
- **State REQ:**
  - imem_req=1.
  - gnt & !redirect_valid -> WAIT.
  - gnt & redirect_valid -> pc<=redirect_pc, DROP (granted fetch is wrong-path).
  - !gnt & redirect_valid -> pc<=redirect_pc, stay REQ; the new address appears next cycle.
- **State WAIT:**
  - imem_req=0.
  - redirect_valid (with or without rvalid) -> pc<=redirect_pc; go REQ if rvalid, else DROP.
  - rvalid & !redirect_valid & IF/ID can load -> load IF/ID, pc<=pc+4, REQ.
  - rvalid & !redirect_valid & IF/ID cannot load -> skid<={pc,rdata}, pc<=pc+4, HOLD.
- **State HOLD:**
  - imem_req=0.
  - redirect_valid -> discard skid, pc<=redirect_pc, REQ.
  - IF/ID can load -> move skid into IF/ID, REQ.
  - Otherwise remain in HOLD.
- **State DROP:**
  - imem_req=0.
  - rvalid -> discard data, REQ.
  - redirect_valid -> pc<=redirect_pc (latest redirect wins), stay DROP, or go REQ if rvalid in the same cycle.
- **"IF/ID can load":** !if_id_valid | !id_stall.
- **IF/ID update priority (highest first):**
  - rst.
  - redirect_valid -> if_id_valid<=0, inst<=NOP_INST (flush overrides stall).
  - if_id_valid & id_stall -> hold all fields.
  - load -> valid<=1 and pc/pc4/inst from the source.
  - Otherwise valid<=0, inst<=NOP_INST.
- **Arithmetic:** pc+4 and if_id_pc4 wrap mod 2^32 (32'hFFFF_FFFC -> 0).
- **Throughput:** 1 instruction per 2 cycles minimum with 1-cycle memory. Latency gnt -> if_id_valid equals memory latency + 1 cycle.

Test Plan:
- **Reset fetch:** rst 2 cycles; memory grants immediately and responds 1 cycle later with 0x00500093 -> imem_addr=0x0 on the first post-reset cycle; if_id_valid=1, if_id_pc=0, if_id_pc4=4, if_id_inst=0x00500093; the next request has addr=0x4.
- **Stall into skid:**
  - Setup: id_stall=1 with IF/ID valid (pc 0x10) while the response for 0x14 arrives.
  - Response: state HOLD, IF/ID still holds 0x10, no imem_req.
  - Release id_stall -> the next cycle IF/ID pc=0x14, and the next request addr=0x18.
- **Redirect in WAIT:** request 0x20 granted; redirect_valid with redirect_pc=0x100 before rvalid -> the response for 0x20 is discarded (if_id_valid stays 0); the next request addr=0x100.
- **Redirect vs stall:** IF/ID valid with id_stall=1, redirect_valid=1, redirect_pc=0x203 -> if_id_valid=0 next cycle; the next request addr=0x200.
- **Wrap:** redirect to 0xFFFF_FFFC; fetch completes -> if_id_pc4=0x0 and the next imem_addr=0x0.
- **Simultaneous gnt+redirect in REQ:** gnt for 0x40 together with redirect to 0x80 -> the 0x40 response is dropped; the 0x80 fetch is the next delivered to IF/ID.
